ddr3_row_responder: RTL

// Memory-side responder for the PIM request/response interface: accepts one line-read request
// at a time and sequences DDR3-style PRE/ACT/RD commands against a per-bank open-row table.

---
 rtl/ddr3_row_responder_if.sv | 20 ++
 rtl/ddr3_row_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ddr3_row_responder_if.sv
// Request/response channel between the PIM request port and the DDR3 row responder.
// The master issues line reads and consumes responses; the slave is the responder.
interface ddr3_row_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic [511:0] resp_data;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ddr3_row_responder.sv
// Single-outstanding DDR3 line-read responder with PRE/ACT/RD sequencing and command counters.
// Define PIM_ROW_SKIP_EN for the open-page policy; the default build uses closed-page.
module ddr3_row_responder #(
  parameter int COL_BITS  = 7,
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 14,
  parameter int T_RP      = 6,
  parameter int T_RCD     = 6,
  parameter int T_CL      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  ddr3_row_responder_if.slave   bus,
  output logic [31:0]           act_count,
  output logic [31:0]           rd_count,
  output logic [31:0]           pre_count,
  output logic [31:0]           skip_count
);

`ifdef PIM_ROW_SKIP_EN
  localparam bit ROW_SKIP = 1'b1;
`else
  localparam bit ROW_SKIP = 1'b0;
`endif

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int BANK_LSB  = 6 + COL_BITS;
  localparam int ROW_LSB   = BANK_LSB + BANK_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRE, S_ACT, S_RD, S_WAIT, S_RESP, S_CLOSE
  } state_t;

  state_t               state, next_state, wait_ret, next_ret;
  logic [7:0]           wait_cnt, next_wait_cnt;
  logic [BANK_BITS-1:0] bank_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [511:0]         resp_data_q;
  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_BITS-1:0]  bank_row [NUM_BANKS];
  logic [31:0]          line_base;
  logic                 accept, do_pre, do_act, do_rd, do_skip;

  assign line_base      = bus.req_addr & 32'hFFFF_FFC0;
  assign bus.req_ready  = (state == S_IDLE) && !rst;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_data  = resp_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      wait_ret <= S_IDLE;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
      wait_ret <= next_ret;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    next_ret      = wait_ret;
    accept        = 1'b0;
    do_pre        = 1'b0;
    do_act        = 1'b0;
    do_rd         = 1'b0;
    do_skip       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ROW_SKIP && bank_open[bank_q] && bank_row[bank_q] == row_q) begin
          do_skip    = 1'b1;
          next_state = S_RD;
        end else if (ROW_SKIP && bank_open[bank_q]) begin
          next_state = S_PRE;
        end else begin
          next_state = S_ACT;
        end
      end
      S_PRE: begin
        do_pre     = 1'b1;
        next_state = S_ACT;
        if (T_RP > 1) begin
          next_state    = S_WAIT;
          next_wait_cnt = 8'(T_RP - 1);
          next_ret      = S_ACT;
        end
      end
      S_ACT: begin
        do_act     = 1'b1;
        next_state = S_RD;
        if (T_RCD > 1) begin
          next_state    = S_WAIT;
          next_wait_cnt = 8'(T_RCD - 1);
          next_ret      = S_RD;
        end
      end
      S_RD: begin
        do_rd      = 1'b1;
        next_state = S_RESP;
        if (T_CL > 1) begin
          next_state    = S_WAIT;
          next_wait_cnt = 8'(T_CL - 1);
          next_ret      = S_RESP;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 8'd1) next_state = wait_ret;
        else                  next_wait_cnt = wait_cnt - 8'd1;
      end
      S_RESP: begin
        if (bus.resp_ready) next_state = ROW_SKIP ? S_IDLE : S_CLOSE;
      end
      S_CLOSE: begin
        do_pre     = 1'b1;
        next_state = S_IDLE;
        if (T_RP > 1) begin
          next_state    = S_WAIT;
          next_wait_cnt = 8'(T_RP - 1);
          next_ret      = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      row_q       <= '0;
      resp_data_q <= '0;
      bank_open   <= '0;
      act_count   <= '0;
      rd_count    <= '0;
      pre_count   <= '0;
      skip_count  <= '0;
    end else begin
      if (accept) begin
        bank_q <= bus.req_addr[BANK_LSB +: BANK_BITS];
        row_q  <= bus.req_addr[ROW_LSB +: ROW_BITS];
        for (int i = 0; i < 16; i++) resp_data_q[32*i +: 32] <= line_base + 32'(4 * i);
      end
      if (do_pre) begin
        pre_count         <= pre_count + 32'd1;
        bank_open[bank_q] <= 1'b0;
      end
      if (do_act) begin
        act_count         <= act_count + 32'd1;
        bank_open[bank_q] <= 1'b1;
      end
      if (do_rd)   rd_count   <= rd_count + 32'd1;
      if (do_skip) skip_count <= skip_count + 32'd1;
    end
  end

  // NOTE: row storage has no reset; it is only read while the bank's reset-cleared open bit is set.
  always_ff @(posedge clk) begin
    if (do_act) bank_row[bank_q] <= row_q;
  end

endmodule
